// File: rtl/cpu_checker_pkg.sv
// Shared types and constants for the cpu_checker trace-line syntax checker.
package cpu_checker_pkg;

  typedef enum logic [4:0] {
    IDLE,
    CARET,
    TIME,
    AT,
    PC,
    COLON,
    SPACE1,
    REG,
    GRF,
    STAR,
    ADDR,
    SPACE2,
    LT,
    EQ,
    DATA,
    DONE_REG,
    DONE_MEM
  } state_e;

  localparam logic [1:0] FORMAT_NONE = 2'b00;
  localparam logic [1:0] FORMAT_REG  = 2'b01;
  localparam logic [1:0] FORMAT_MEM  = 2'b10;

  localparam logic [7:0] ASCII_CARET  = 8'h5e;
  localparam logic [7:0] ASCII_AT     = 8'h40;
  localparam logic [7:0] ASCII_COLON  = 8'h3a;
  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_STAR   = 8'h2a;
  localparam logic [7:0] ASCII_LT     = 8'h3c;
  localparam logic [7:0] ASCII_EQ     = 8'h3d;
  localparam logic [7:0] ASCII_HASH   = 8'h23;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;

endpackage

// File: rtl/cpu_checker_char_class.sv
// Combinational character classifier: decimal, lowercase hex, space, and hex nibble value.
module cpu_checker_char_class
  import cpu_checker_pkg::*;
(
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic       is_space,
  output logic [3:0] hex_val
);

  always_comb begin
    is_dec   = (char >= 8'h30) && (char <= 8'h39);
    is_hex   = is_dec || ((char >= 8'h61) && (char <= 8'h66));
    is_space = (char == ASCII_SPACE);
    hex_val  = '0;
    if (is_dec) begin
      hex_val = char[3:0];
    end else if (is_hex) begin
      hex_val = char[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/cpu_checker.sv
// Streaming CPU trace-line checker; format_type reports the line kind the cycle after '#'.
// Optional field-range checks (freq/error_code ports) are enabled by defining CPU_CHECKER_ERR_EN.
module cpu_checker
  import cpu_checker_pkg::*;
#(
  parameter int unsigned TIME_MAX_DIGITS = 4,
  parameter int unsigned GRF_MAX_DIGITS  = 4,
  parameter int unsigned HEX_DIGITS      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
`ifdef CPU_CHECKER_ERR_EN
  input  logic [15:0] freq,
  output logic [3:0]  error_code,
`endif
  output logic [1:0]  format_type
);

  localparam int unsigned MAX_TG  = (TIME_MAX_DIGITS > GRF_MAX_DIGITS) ? TIME_MAX_DIGITS : GRF_MAX_DIGITS;
  localparam int unsigned CNT_MAX = (MAX_TG > HEX_DIGITS) ? MAX_TG : HEX_DIGITS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TIME_LIM = CNT_W'(TIME_MAX_DIGITS);
  localparam logic [CNT_W-1:0] GRF_LIM  = CNT_W'(GRF_MAX_DIGITS);
  localparam logic [CNT_W-1:0] HEX_LIM  = CNT_W'(HEX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_line_q, mem_line_d;

  logic       is_dec, is_hex, is_space;
  logic [3:0] hex_val;

  cpu_checker_char_class u_char_class (
    .char     (char),
    .is_dec   (is_dec),
    .is_hex   (is_hex),
    .is_space (is_space),
    .hex_val  (hex_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_line_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_line_q <= mem_line_d;
    end
  end

  // Counters only advance below their limit, so one more digit falls through to IDLE.
  always_comb begin
    state_d    = IDLE;
    cnt_d      = cnt_q;
    mem_line_d = mem_line_q;
    if (char == ASCII_CARET) begin
      state_d    = CARET;
      cnt_d      = '0;
      mem_line_d = 1'b0;
    end else begin
      case (state_q)
        CARET: if (is_dec) begin state_d = TIME; cnt_d = CNT_ONE; end
        TIME: begin
          if (is_dec && (cnt_q < TIME_LIM)) begin
            state_d = TIME;
            cnt_d   = cnt_q + 1'b1;
          end else if (char == ASCII_AT) begin
            state_d = AT;
          end
        end
        AT: if (is_hex) begin state_d = PC; cnt_d = CNT_ONE; end
        PC: begin
          if (is_hex && (cnt_q < HEX_LIM)) begin
            state_d = PC;
            cnt_d   = cnt_q + 1'b1;
          end else if ((char == ASCII_COLON) && (cnt_q == HEX_LIM)) begin
            state_d = COLON;
          end
        end
        COLON, SPACE1: begin
          if (is_space) begin
            state_d = SPACE1;
          end else if (char == ASCII_DOLLAR) begin
            state_d    = REG;
            mem_line_d = 1'b0;
          end else if (char == ASCII_STAR) begin
            state_d    = STAR;
            mem_line_d = 1'b1;
          end
        end
        REG: if (is_dec) begin state_d = GRF; cnt_d = CNT_ONE; end
        GRF: begin
          if (is_dec && (cnt_q < GRF_LIM)) begin
            state_d = GRF;
            cnt_d   = cnt_q + 1'b1;
          end else if (is_space) begin
            state_d = SPACE2;
          end else if (char == ASCII_LT) begin
            state_d = LT;
          end
        end
        STAR: if (is_hex) begin state_d = ADDR; cnt_d = CNT_ONE; end
        ADDR: begin
          if (is_hex && (cnt_q < HEX_LIM)) begin
            state_d = ADDR;
            cnt_d   = cnt_q + 1'b1;
          end else if (cnt_q == HEX_LIM) begin
            if (is_space) state_d = SPACE2;
            else if (char == ASCII_LT) state_d = LT;
          end
        end
        SPACE2: begin
          if (is_space) state_d = SPACE2;
          else if (char == ASCII_LT) state_d = LT;
        end
        LT: if (char == ASCII_EQ) state_d = EQ;
        EQ: begin
          if (is_space) begin
            state_d = EQ;
          end else if (is_hex) begin
            state_d = DATA;
            cnt_d   = CNT_ONE;
          end
        end
        DATA: begin
          if (is_hex && (cnt_q < HEX_LIM)) begin
            state_d = DATA;
            cnt_d   = cnt_q + 1'b1;
          end else if ((char == ASCII_HASH) && (cnt_q == HEX_LIM)) begin
            state_d = mem_line_q ? DONE_MEM : DONE_REG;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      DONE_REG: format_type = FORMAT_REG;
      DONE_MEM: format_type = FORMAT_MEM;
      default:  format_type = FORMAT_NONE;
    endcase
  end

`ifdef CPU_CHECKER_ERR_EN
  localparam int unsigned HEX_W = 4 * HEX_DIGITS;

  logic [31:0]      time_q, grf_q;
  logic [HEX_W-1:0] pc_q, addr_q;
  logic [15:0]      half_freq;

  // Entering a field state implies the current char is a digit of that field.
  always_ff @(posedge clk) begin
    if (reset || (char == ASCII_CARET)) begin
      time_q <= '0;
      grf_q  <= '0;
      pc_q   <= '0;
      addr_q <= '0;
    end else begin
      if (state_d == TIME) time_q <= time_q * 32'd10 + 32'(hex_val);
      if (state_d == GRF)  grf_q  <= grf_q * 32'd10 + 32'(hex_val);
      if (state_d == PC)   pc_q   <= {pc_q[HEX_W-5:0], hex_val};
      if (state_d == ADDR) addr_q <= {addr_q[HEX_W-5:0], hex_val};
    end
  end

  always_comb begin
    half_freq  = freq >> 1;
    error_code = '0;
    if (format_type != FORMAT_NONE) begin
      error_code[0] = (half_freq != '0) && ((time_q % 32'(half_freq)) != '0);
      error_code[1] = (pc_q < HEX_W'(32'h3000)) || (pc_q > HEX_W'(32'h4fff)) || (pc_q[1:0] != 2'b00);
      error_code[2] = (state_q == DONE_MEM) &&
                      ((addr_q > HEX_W'(32'h2fff)) || (addr_q[1:0] != 2'b00));
      error_code[3] = (state_q == DONE_REG) && (grf_q > 32'd31);
    end
  end
`else
  logic [3:0] unused_hex_val;
  assign unused_hex_val = hex_val;
`endif

endmodule

// File: tb/tb_cpu_checker.sv
// Directed bench for cpu_checker: line-grammar model checked every cycle plus literal spot checks.
module tb_cpu_checker;

  localparam int unsigned TMAX = 4;
  localparam int unsigned GMAX = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char  = 8'h20;
  logic [1:0] format_type;
`ifdef CPU_CHECKER_ERR_EN
  logic [15:0] freq    = 16'd2;
  logic [3:0]  error_code;
  logic [3:0]  exp_err = 4'd0;
`endif

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_fmt = 2'b00;
  bit         active  = 1'b0;
  logic [7:0] line_q[$];

  cpu_checker #(
    .TIME_MAX_DIGITS (4),
    .GRF_MAX_DIGITS  (4),
    .HEX_DIGITS      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
`ifdef CPU_CHECKER_ERR_EN
    .freq        (freq),
    .error_code  (error_code),
`endif
    .format_type (format_type)
  );

  always #5 clk = ~clk;

  function automatic bit is_d(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_h(input logic [7:0] c);
    return is_d(c) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic longint hv(input logic [7:0] c);
    return is_d(c) ? longint'(c - 8'h30) : longint'(c - 8'h61) + 10;
  endfunction

  function automatic bit at(input int unsigned i, input logic [7:0] c);
    return (i < line_q.size()) && (line_q[i] == c);
  endfunction

  // Whole-line grammar match over the characters collected since the last '^'.
  function automatic void parse(output logic [1:0] kind, output longint t, output longint p,
                                output longint g, output longint a);
    int unsigned i, n;
    bit ismem;
    kind = 2'b00; t = 0; p = 0; g = 0; a = 0; i = 0; ismem = 1'b0;
    n = 0;
    while (i < line_q.size() && is_d(line_q[i])) begin t = t * 10 + hv(line_q[i]); i++; n++; end
    if (n < 1 || n > TMAX) return;
    if (!at(i, 8'h40)) return;
    i++;
    n = 0;
    while (i < line_q.size() && is_h(line_q[i])) begin p = p * 16 + hv(line_q[i]); i++; n++; end
    if (n != 8) return;
    if (!at(i, 8'h3a)) return;
    i++;
    while (at(i, 8'h20)) i++;
    if (at(i, 8'h24)) ismem = 1'b0;
    else if (at(i, 8'h2a)) ismem = 1'b1;
    else return;
    i++;
    n = 0;
    if (!ismem) begin
      while (i < line_q.size() && is_d(line_q[i])) begin g = g * 10 + hv(line_q[i]); i++; n++; end
      if (n < 1 || n > GMAX) return;
    end else begin
      while (i < line_q.size() && is_h(line_q[i])) begin a = a * 16 + hv(line_q[i]); i++; n++; end
      if (n != 8) return;
    end
    while (at(i, 8'h20)) i++;
    if (!at(i, 8'h3c)) return;
    i++;
    if (!at(i, 8'h3d)) return;
    i++;
    while (at(i, 8'h20)) i++;
    n = 0;
    while (i < line_q.size() && is_h(line_q[i])) begin i++; n++; end
    if (n != 8) return;
    if (!at(i, 8'h23) || (i + 1 != line_q.size())) return;
    kind = ismem ? 2'b10 : 2'b01;
  endfunction

  // Model: evaluates each posedge from the sampled inputs.
  initial begin
    logic [1:0] k;
    longint t, p, g, a;
    forever begin
      @(posedge clk);
      exp_fmt = 2'b00;
`ifdef CPU_CHECKER_ERR_EN
      exp_err = 4'd0;
`endif
      if (reset) begin
        active = 1'b0;
        line_q.delete();
      end else if (char == 8'h5e) begin
        active = 1'b1;
        line_q.delete();
      end else if (active) begin
        line_q.push_back(char);
        if (char == 8'h23) begin
          parse(k, t, p, g, a);
          exp_fmt = k;
`ifdef CPU_CHECKER_ERR_EN
          if (k != 2'b00) begin
            exp_err[0] = (t % longint'(freq / 2)) != 0;
            exp_err[1] = (p < 'h3000) || (p > 'h4fff) || ((p % 4) != 0);
            exp_err[2] = (k == 2'b10) && ((a > 'h2fff) || ((a % 4) != 0));
            exp_err[3] = (k == 2'b01) && (g > 31);
          end
`endif
        end
      end
    end
  end

  // Compare: outputs settle after the posedge; check at the following negedge.
  initial begin
    forever begin
      @(negedge clk);
      total++;
      if (format_type !== exp_fmt) begin
        bad++;
        $display("FAIL cycle_fmt t=%0t got=%b want=%b", $time, format_type, exp_fmt);
      end
`ifdef CPU_CHECKER_ERR_EN
      total++;
      if (error_code !== exp_err) begin
        bad++;
        $display("FAIL cycle_err t=%0t got=%b want=%b", $time, error_code, exp_err);
      end
`endif
    end
  end

  task automatic send_char(input logic [7:0] c);
    char = c;
    @(posedge clk);
    #2;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic check_lit(input string name, input logic [1:0] fmt, input logic [3:0] err);
    total++;
    if (format_type !== fmt) begin
      bad++;
      $display("FAIL %s fmt got=%b want=%b", name, format_type, fmt);
    end
    total++;
    if (exp_fmt !== fmt) begin
      bad++;
      $display("FAIL %s model_fmt got=%b want=%b", name, exp_fmt, fmt);
    end
`ifdef CPU_CHECKER_ERR_EN
    total++;
    if (error_code !== err) begin
      bad++;
      $display("FAIL %s err got=%b want=%b", name, error_code, err);
    end
`else
    if (err != err) $display("FAIL %s unreachable", name);
`endif
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) send_char(8'h20);
    check_lit("reset", 2'b00, 4'b0000);
    reset = 1'b0;

    send_line("^242@00003f04: $31 <= 12345678#");
    check_lit("reg_basic", 2'b01, 4'b0000);
    send_char("x");
    check_lit("reg_one_cycle", 2'b00, 4'b0000);

    send_line("^338@00003130: *00000088 <=   ffffb528#");
    check_lit("mem_basic", 2'b10, 4'b0000);
    send_line("^338@00003130: *00000088 <=   Ffffb528#");
    check_lit("mem_upper_hex", 2'b00, 4'b0000);

    send_line("^33348@00003130: *00000088 <= ffffb528#");
    check_lit("time_5_digits", 2'b00, 4'b0000);
    send_line("^3321  @  00003130: *00000088 <= ffffb528#");
    check_lit("space_at", 2'b00, 4'b0000);
    send_line("^3321@00003130: *00000088 <= ffffb528#");
    check_lit("recover_mem", 2'b10, 4'b0000);

    send_line("^66@0000301c: $1 <=  1e1 f831e#");
    check_lit("space_in_data", 2'b00, 4'b0000);
    send_line("^66@0000301c: $1 <=  1e1f831e#");
    check_lit("reg_data_ok", 2'b01, 4'b0000);

    send_line("^242@00");
    reset = 1'b1;
    send_char("0");
    reset = 1'b0;
    check_lit("reset_mid", 2'b00, 4'b0000);
    send_line("^242@00003f04: $31 <= 12345678#");
    check_lit("after_reset", 2'b01, 4'b0000);

    send_line("^242@00002ffe: $40 <= 12345678#");
    check_lit("bad_pc_grf", 2'b01, 4'b1010);

    send_line("^9999@00003000:$0<=00000000#");
    check_lit("time_4_nospace", 2'b01, 4'b0000);
    send_line("^1@00003000: $1234 <= 0000abcd#");
    check_lit("grf_4_digits", 2'b01, 4'b1000);
    send_line("^1@00003000: $12345 <= 0000abcd#");
    check_lit("grf_5_digits", 2'b00, 4'b0000);
    send_line("^1@0000300: $1 <= 00000000#");
    check_lit("pc_7_digits", 2'b00, 4'b0000);
    send_line("^1@00003000: $1 < =00000000#");
    check_lit("lt_space_eq", 2'b00, 4'b0000);
    send_line("^@00003000: $1 <= 00000000#");
    check_lit("empty_time", 2'b00, 4'b0000);

    send_line("^7@00004ffc: *00002ffc<=00000000#");
    check_lit("mem_edge_ok", 2'b10, 4'b0000);
    send_line("^8@00005000: *00003000 <= 00000001#");
    check_lit("back_to_back", 2'b10, 4'b0110);

`ifdef CPU_CHECKER_ERR_EN
    freq = 16'd4;
`endif
    send_line("^7@00003001: $0 <= 00000000#");
    check_lit("odd_time_pc", 2'b01, 4'b0011);
    send_char("x");
`ifdef CPU_CHECKER_ERR_EN
    freq = 16'd2;
`endif
    repeat (3) send_char(8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
